// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit : fetch sequencer feeding the instruction register
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ir_load,
  output logic [31:0] ir_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_LOAD = 2'd3
  } state_e;

  state_e      state_q;
  logic        kill_q;
  logic [31:0] pc_q;
  logic [31:0] mem_addr_q;
  logic [31:0] ir_data_q;
  logic        addr_err_q;

  logic        redir_ok;
  logic        redir_bad;
  logic        kill_d;

  assign redir_ok  = redirect & (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect & (redirect_pc[1:0] != 2'b00);

  // A redirect arriving in the same cycle as the response must still drop it.
  assign kill_d = kill_q | (redir_ok & ((state_q == S_REQ) | (state_q == S_WAIT)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kill_q     <= 1'b0;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      ir_data_q  <= 32'h0000_0000;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= redir_bad;

      case (state_q)
        S_IDLE: begin
          if (fetch_en) begin
            mem_addr_q <= redir_ok ? redirect_pc : pc_q;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          kill_q <= kill_d;
          if (mem_gnt) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            kill_q <= 1'b0;
            if (kill_d) begin
              state_q <= S_IDLE;
            end else begin
              ir_data_q <= mem_rdata;
              state_q   <= S_LOAD;
            end
          end else begin
            kill_q <= kill_d;
          end
        end
        S_LOAD: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (redir_ok) begin
        pc_q <= redirect_pc;
      end else if (state_q == S_LOAD) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  assign mem_req  = (state_q == S_REQ);
  assign busy     = (state_q != S_IDLE);
  assign ir_load  = (state_q == S_LOAD) & ~redir_ok;
  assign mem_addr = mem_addr_q;
  assign ir_data  = ir_data_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign addr_err = addr_err_q;

endmodule
`default_nettype wire
